// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback request/grant bundle between sources and the register-file write port
interface regfile_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [3:0]    req;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [AW-1:0] addr3;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [DW-1:0] data3;
  logic          stall;
  logic [3:0]    ack;
  logic [1:0]    sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output req, addr0, addr1, addr2, addr3, data0, data1, data2, data3, stall,
    input  ack, sel, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, addr0, addr1, addr2, addr3, data0, data1, data2, data3, stall,
    output ack, sel, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter sharing one register-file write port among four writeback sources
module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input logic                clk,
  input logic                rst,
  regfile_wr_arbiter_if.slave bus
);
  logic [3:0]    ack_q;
  logic [1:0]    sel_q;
  logic [1:0]    ptr_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic [3:0]    elig;
  logic [1:0]    idx;
  logic [1:0]    g;
  logic          found;
  logic [AW-1:0] addr_g;
  logic [DW-1:0] data_g;

  // A source acked this cycle is masked so a still-held request is not granted twice.
  assign elig = bus.req & ~ack_q;

  always_comb begin
    g     = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    addr_g = bus.addr0;
    data_g = bus.data0;
    case (g)
      2'd0: begin addr_g = bus.addr0; data_g = bus.data0; end
      2'd1: begin addr_g = bus.addr1; data_g = bus.data1; end
      2'd2: begin addr_g = bus.addr2; data_g = bus.data2; end
      default: begin addr_g = bus.addr3; data_g = bus.data3; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 4'b0000;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd3;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (!bus.stall && found) begin
      ack_q     <= 4'b0001 << g;
      sel_q     <= g;
      ptr_q     <= g;
      wr_en_q   <= (addr_g != '0);
      wr_addr_q <= addr_g;
      wr_data_q <= data_g;
    end else begin
      ack_q   <= 4'b0000;
      wr_en_q <= 1'b0;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.sel     = sel_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - scoreboard bench for regfile_wr_arbiter with directed and random writeback traffic
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.AW(5), .DW(32)) bus ();
  regfile_wr_arbiter #(.AW(5), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]  ack;
    logic [1:0]  sel;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [3:0]  r_req;
  logic [4:0]  r_addr [4];
  logic [31:0] r_data [4];

  // Reference model state: ack history, last-granted index, and held output values.
  int   m_ptr = 3;
  logic [3:0] m_ack = 4'b0;
  exp_t m_out = '0;

  task automatic apply();
    bus.req   = r_req;
    bus.addr0 = r_addr[0]; bus.addr1 = r_addr[1];
    bus.addr2 = r_addr[2]; bus.addr3 = r_addr[3];
    bus.data0 = r_data[0]; bus.data1 = r_data[1];
    bus.data2 = r_data[2]; bus.data3 = r_data[3];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0]  elig;
    logic [4:0]  a [4];
    logic [31:0] d [4];
    int g;
    a[0] = bus.addr0; a[1] = bus.addr1; a[2] = bus.addr2; a[3] = bus.addr3;
    d[0] = bus.data0; d[1] = bus.data1; d[2] = bus.data2; d[3] = bus.data3;
    if (rst) begin
      m_ptr = 3;
      m_out = '0;
    end else begin
      elig = bus.req & ~m_ack;
      g = -1;
      for (int k = 1; k <= 4; k++)
        if (g < 0 && elig[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      if (bus.stall || g < 0) begin
        m_out.ack   = 4'b0;
        m_out.wr_en = 1'b0;
      end else begin
        m_out.ack     = 4'b0;
        m_out.ack[g]  = 1'b1;
        m_out.sel     = 2'(g);
        m_out.wr_addr = a[g];
        m_out.wr_data = d[g];
        m_out.wr_en   = (a[g] != 5'd0);
        m_ptr = g;
      end
    end
    m_ack = m_out.ack;
    q.push_back(m_out);
  end

  always @(posedge clk) begin
    exp_t e;
    exp_t act;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {bus.ack, bus.sel, bus.wr_en, bus.wr_addr, bus.wr_data};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t actual ack=%b sel=%0d en=%b addr=%0d data=%h expected ack=%b sel=%0d en=%b addr=%0d data=%h",
                 $time, act.ack, act.sel, act.wr_en, act.wr_addr, act.wr_data,
                 e.ack, e.sel, e.wr_en, e.wr_addr, e.wr_data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    r_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      r_addr[i] = 5'(i + 1);
      r_data[i] = 32'hA000_0000 + 32'(i);
    end
    apply();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", {28'd0, bus.ack}, 32'd0);
    chk("reset_wr_data", bus.wr_data, 32'd0);

    // Contention: all four held, grants rotate 0,1,2,3,0.
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rotate_ack", {28'd0, bus.ack}, 32'd1 << (i % 4));
      chk("rotate_sel", {30'd0, bus.sel}, 32'(i % 4));
    end
    @(negedge clk); r_req = 4'b0; apply();
    @(posedge clk);

    @(negedge clk);
    r_req = 4'b0010; r_addr[1] = 5'd9; r_data[1] = 32'hDEADBEEF; apply();
    @(posedge clk); #1;
    chk("single_ack", {28'd0, bus.ack}, 32'b0010);
    chk("single_addr", {27'd0, bus.wr_addr}, 32'd9);
    chk("single_data", bus.wr_data, 32'hDEADBEEF);
    @(negedge clk); r_req = 4'b0; apply();
    @(posedge clk); #1;
    chk("single_drop_en", {31'd0, bus.wr_en}, 32'd0);

    @(negedge clk); r_req = 4'b0100; apply();
    @(posedge clk); #1;
    chk("fair_g2", {28'd0, bus.ack}, 32'b0100);
    @(negedge clk); r_req = 4'b0101; apply();
    @(posedge clk); #1;
    chk("fair_g0", {28'd0, bus.ack}, 32'b0001);
    @(posedge clk); #1;
    chk("fair_g2b", {28'd0, bus.ack}, 32'b0100);
    @(negedge clk); r_req = 4'b0; apply();

    @(negedge clk);
    r_req = 4'b1000; r_addr[3] = 5'd0; r_data[3] = 32'h1234; apply();
    @(posedge clk); #1;
    chk("zero_ack", {28'd0, bus.ack}, 32'b1000);
    chk("zero_en", {31'd0, bus.wr_en}, 32'd0);
    @(negedge clk); r_req = 4'b0001; r_addr[0] = 5'd4; apply();
    @(posedge clk); #1;
    chk("after_zero_en", {31'd0, bus.wr_en}, 32'd1);
    @(negedge clk); r_req = 4'b0; apply();

    @(negedge clk);
    r_req = 4'b0100; r_addr[2] = 5'd7; bus.stall = 1'b1; apply();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_ack", {28'd0, bus.ack}, 32'd0);
    end
    @(negedge clk); bus.stall = 1'b0;
    @(posedge clk); #1;
    chk("unstall_ack", {28'd0, bus.ack}, 32'b0100);
    @(negedge clk); rst = 1'b1; r_req = 4'b1111; apply();
    @(posedge clk); #1;
    chk("midrst_en", {31'd0, bus.wr_en}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_ack", {28'd0, bus.ack}, 32'b0001);
    @(negedge clk); r_req = 4'b0; apply();

    // Random traffic obeying the requester protocol, with occasional stall and reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) < 2);
      bus.stall = ($urandom_range(0, 99) < 20);
      for (int i = 0; i < 4; i++) begin
        if (!r_req[i] || bus.ack[i]) begin
          r_req[i] = ($urandom_range(0, 99) < 50);
          r_addr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          r_data[i] = $urandom;
        end
      end
      apply();
    end

    @(negedge clk); rst = 1'b0; bus.stall = 1'b0; r_req = 4'b0; apply();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port among four writeback sources: ALU result, load data, JAL link and CP0/HI-LO move. Each source raises a request carrying a 5-bit destination address and 32-bit data. The block grants one source per cycle with round-robin fairness and drives the 2-bit select of the 4:1 5-bit write-address mux and its 32-bit data companion. Outputs are registered and feed the register-file write port directly.

Parameters:
AW, 5, register address width
DW, 32, write data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  4  per-source write request; bit i = source i
addr0  input  AW  destination register, source 0
addr1  input  AW  destination register, source 1
addr2  input  AW  destination register, source 2
addr3  input  AW  destination register, source 3
data0  input  DW  write data, source 0
data1  input  DW  write data, source 1
data2  input  DW  write data, source 2
data3  input  DW  write data, source 3
stall  input  1  write port unavailable this cycle; no grant issued
ack  output  4  one-hot, one-cycle acknowledge of the granted source
sel  output  2  index of the last granted source; drives the 4:1 address/data mux select
wr_en  output  1  register-file write enable
wr_addr  output  AW  register-file write address
wr_data  output  DW  register-file write data

Behaviour:
- One clock; reset is synchronous and active-high. Signals are clk and rst. Reset has priority over all other inputs.
- Reset values: ack=0, wr_en=0, sel=0, wr_addr=0, wr_data=0, internal round-robin pointer ptr=3.
- Eligible set each cycle: elig = req & ~ack. A source whose ack is currently high is masked, so a request still held during its ack cycle is never granted twice.
- Grant search order: ptr+1, ptr+2, ptr+3, ptr, all modulo 4. The first eligible index found is g. After reset, the order is 0,1,2,3.
- Edge with stall=0 and elig!=0:
  - ack <= onehot(g)
  - sel <= g
  - wr_addr <= addr_g
  - wr_data <= data_g
  - wr_en <= (addr_g != 0)
  - ptr <= g
- Latency: request sampled at edge N; ack, wr_en and the address/data appear after edge N and are valid during cycle N+1. Exactly one grant per cycle.
- Edge with stall=1, or with elig=0: ack<=0, wr_en<=0; sel, wr_addr, wr_data and ptr hold.
- Writes to register 0: the source is still acked (the request is consumed), but wr_en=0. The ptr update still occurs.
- Requester protocol:
  - Hold req and addr/data stable until ack is seen high.
  - In the ack cycle, either drop req or present the next transaction. That new transaction is eligible no earlier than the following edge.
  - Changing addr/data while req is high without an ack is illegal; the value sampled at the grant edge is the one written.
- Requests dropped before being acked are simply not served; no state is kept per requester besides ptr.
- Reset mid-operation: any pending ack or wr_en is cleared on the reset edge and ptr returns to 3. In-flight unacked requests must be re-presented; if still high after reset, they are arbitrated from index 0.
- sel always equals the index in the currently or most recently asserted ack.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> ack=0, wr_en=0, sel=0, wr_addr=0, wr_data=0 throughout. First grant after release is source 0.
- Single request: req=4'b0010, addr1=5'd9, data1=32'hDEADBEEF -> next cycle ack=4'b0010, sel=2'd1, wr_en=1, wr_addr=9, wr_data=32'hDEADBEEF. Requester drops req -> following cycle ack=0, wr_en=0.
- Contention: req=4'b1111 held continuously, distinct nonzero addresses -> acks rotate 0001,0010,0100,1000,0001 on consecutive cycles, wr_en=1 every cycle, sel=0,1,2,3,0.
- Rotation fairness: after grant to source 2, req=4'b0101 -> next grant is source 0, then source 2. Source 2 is never granted back-to-back while source 0 is waiting.
- $zero write: req=4'b1000, addr3=0, data3=32'h1234 -> ack=4'b1000, wr_en=0. Subsequent req=4'b0001 with addr0=5'd4 -> ack=4'b0001, wr_en=1.
- Stall and reset: req=4'b0100, stall=1 for 3 cycles -> no ack, wr_en=0. Stall deasserts -> ack=4'b0100 next cycle. Assert rst during a cycle with wr_en=1 -> next cycle all outputs 0 and next grant searches from source 0.
